sbox_sub_engine: RTL and testbench

Parametrised SubBytes engine. It runs the AES forward or inverse S-box over an NBYTES-byte state, using PORTS synchronous-read ROM lookup lanes that are time-multiplexed across the state. It sits between the round-key/ShiftRows datapath and the round controller in the encrypt/decrypt cores, and replaces fixed 4-lane lookups with a configurable lane count, a per-transaction direction select and a valid/ready handshake.

---
 rtl/sbox_sub_engine.sv | 164 ++++++++++++++++
 tb/tb_sbox_sub_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_sub_engine.sv
// sbox_sub_engine: forward/inverse AES SubBytes over an NBYTES state
// using PORTS time-multiplexed registered-read S-box lanes.
module sbox_sub_engine #(
  parameter int NBYTES = 16,
  parameter int PORTS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [8*NBYTES-1:0] in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_state,
  output logic                busy
);

  localparam int G  = NBYTES / PORTS;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  if (PORTS < 1 || PORTS > NBYTES || (NBYTES % PORTS) != 0) begin : g_chk
    $error("NBYTES must be a multiple of PORTS, 1 <= PORTS <= NBYTES");
  end

  typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grp_q, grp_d, cgrp_q;
  logic                cap_q;
  logic                inv_q;
  logic [8*NBYTES-1:0] st_q, res_q;
  logic [7:0]          rom_q [PORTS];
  logic                accept;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fsb(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] a);
    logic [7:0] b;
    b = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == LOOKUP) || (state_q == DRAIN);
  assign out_state = res_q;

  // Next-state, group counter and input handshake
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = LOOKUP;
          grp_d   = '0;
        end
      end
      LOOKUP: begin
        if (grp_q == GW'(G - 1)) begin
          state_d = DRAIN;
          grp_d   = '0;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d = LOOKUP;
            grp_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // FSM state and group registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
    end
  end

  // Latch the operand on accept and write back each group one edge after issue
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= '0;
      inv_q  <= 1'b0;
      res_q  <= '0;
      cap_q  <= 1'b0;
      cgrp_q <= '0;
    end else begin
      if (accept) begin
        st_q  <= in_state;
        inv_q <= in_inv;
      end
      cap_q  <= (state_q == LOOKUP);
      cgrp_q <= grp_q;
      if (cap_q) begin
        for (int p = 0; p < PORTS; p++) begin
          res_q[8*(NBYTES-1-(int'(cgrp_q)*PORTS+p)) +: 8] <= rom_q[p];
        end
      end
    end
  end

  // Registered-read S-box lanes, direction chosen by the latched inv bit
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      rom_q[p] <= inv_q
        ? isb(st_q[8*(NBYTES-1-(int'(grp_q)*PORTS+p)) +: 8])
        : fsb(st_q[8*(NBYTES-1-(int'(grp_q)*PORTS+p)) +: 8]);
    end
  end

endmodule

// File: tb/tb_sbox_sub_engine.sv
// tb_sbox_sub_engine: directed checks of sbox_sub_engine with
// PORTS = 4, 1, 2 and 16 instances sharing clock and reset.
module tb_sbox_sub_engine;

  logic         clk;
  logic         rst;
  logic         iv   [4];
  logic         ir   [4];
  logic         ii   [4];
  logic [127:0] ist  [4];
  logic         ov   [4];
  logic         ordy [4];
  logic [127:0] ost  [4];
  logic         bz   [4];

  int checks;
  int failures;

  localparam logic [127:0] PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] CNT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CSB = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] Z63 = {16{8'h63}};

  sbox_sub_engine #(.NBYTES(16), .PORTS(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_inv(ii[0]), .in_state(ist[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_state(ost[0]), .busy(bz[0]));

  sbox_sub_engine #(.NBYTES(16), .PORTS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_inv(ii[1]), .in_state(ist[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_state(ost[1]), .busy(bz[1]));

  sbox_sub_engine #(.NBYTES(16), .PORTS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_inv(ii[2]), .in_state(ist[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_state(ost[2]), .busy(bz[2]));

  sbox_sub_engine #(.NBYTES(16), .PORTS(16)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_inv(ii[3]), .in_state(ist[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .out_state(ost[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer a state on lane k and return #1 after the accepting edge
  task automatic start(input int k, input logic [127:0] d, input logic inv);
    int n;
    @(negedge clk);
    ist[k] = d;
    ii[k]  = inv;
    iv[k]  = 1'b1;
    n = 0;
    while (!ir[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ir[k]) begin
      failures++;
      $display("FAIL accept_timeout[%0d]: in_ready=%b required 1", k, ir[k]);
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  // Count edges from accept until out_valid is seen
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ov[k] && lat < 40);
    checks++;
    if (!ov[k]) begin
      failures++;
      $display("FAIL out_timeout[%0d]: out_valid=%b required 1", k, ov[k]);
    end
  endtask

  task automatic release_out(input int k);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_ready: got %b required 0", ir[0]);
    end
    checks++;
    if (ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid: got %b required 0", ov[0]);
    end
    checks++;
    if (ost[0] !== 128'h0) begin
      failures++;
      $display("FAIL rst_out_state: got %h required 0", ost[0]);
    end
    checks++;
    if (bz[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy: got %b required 0", bz[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir[0] !== 1'b1 || ir[3] !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_in_ready: got %b%b required 11", ir[0], ir[3]);
    end
  endtask

  task automatic test_forward();
    int lat;
    start(0, PT, 1'b0);
    checks++;
    if (bz[0] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_busy: got %b required 1", bz[0]);
    end
    wait_out(0, lat);
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL fwd_latency: got %0d required 5", lat);
    end
    checks++;
    if (ost[0] !== SB) begin
      failures++;
      $display("FAIL fwd_state: got %h required %h", ost[0], SB);
    end
    checks++;
    if (bz[0] !== 1'b0 || ir[0] !== 1'b0) begin
      failures++;
      $display("FAIL fwd_hold: busy=%b in_ready=%b required 0 0", bz[0], ir[0]);
    end
    release_out(0);
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_release: out_valid=%b in_ready=%b required 0 1",
               ov[0], ir[0]);
    end
  endtask

  task automatic test_inverse();
    int lat;
    start(0, SB, 1'b1);
    wait_out(0, lat);
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL inv_latency: got %0d required 5", lat);
    end
    checks++;
    if (ost[0] !== PT) begin
      failures++;
      $display("FAIL inv_state: got %h required %h", ost[0], PT);
    end
    release_out(0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    start(0, PT, 1'b0);
    wait_out(0, lat);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0] !== 1'b1 || ost[0] !== SB || ir[0] !== 1'b0 || bz[0] !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable: %0d bad cycles state=%h ov=%b ir=%b busy=%b",
               bad, ost[0], ov[0], ir[0], bz[0]);
    end
    ist[0]  = 128'h0;
    ii[0]   = 1'b0;
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_in_ready: got %b required 1", ir[0]);
    end
    @(posedge clk);
    #1;
    iv[0]   = 1'b0;
    ordy[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff: out_valid=%b busy=%b required 0 1", ov[0], bz[0]);
    end
    wait_out(0, lat);
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL bp_latency: got %0d required 5", lat);
    end
    checks++;
    if (ost[0] !== Z63) begin
      failures++;
      $display("FAIL bp_state: got %h required %h", ost[0], Z63);
    end
    release_out(0);
  endtask

  task automatic test_sweep();
    int lat;
    int exp_lat [4];
    exp_lat = '{5, 17, 9, 2};
    for (int k = 1; k < 4; k++) begin
      start(k, CNT, 1'b0);
      wait_out(k, lat);
      checks++;
      if (lat != exp_lat[k]) begin
        failures++;
        $display("FAIL sweep_latency[%0d]: got %0d required %0d",
                 k, lat, exp_lat[k]);
      end
      checks++;
      if (ost[k] !== CSB) begin
        failures++;
        $display("FAIL sweep_state[%0d]: got %h required %h", k, ost[k], CSB);
      end
      release_out(k);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    start(0, CNT, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL mrst_in_ready: got %b required 1", ir[0]);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mrst_discard: %0d cycles with out_valid/busy, required 0",
               seen);
    end
    start(0, PT, 1'b0);
    wait_out(0, lat);
    checks++;
    if (ost[0] !== SB || lat != 5) begin
      failures++;
      $display("FAIL mrst_next: got %h lat %0d required %h lat 5",
               ost[0], lat, SB);
    end
    release_out(0);
  endtask

  task automatic test_mutation();
    int lat;
    start(0, SB, 1'b1);
    lat = 0;
    do begin
      ist[0] = {$urandom, $urandom, $urandom, $urandom};
      ii[0]  = ~ii[0];
      @(posedge clk);
      #1;
      lat++;
    end while (!ov[0] && lat < 40);
    checks++;
    if (ost[0] !== PT || lat != 5) begin
      failures++;
      $display("FAIL mutate_state: got %h lat %0d required %h lat 5",
               ost[0], lat, PT);
    end
    release_out(0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv[k]   = 1'b0;
      ii[k]   = 1'b0;
      ist[k]  = '0;
      ordy[k] = 1'b0;
    end
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_sweep();
    test_mid_reset();
    test_mutation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
